// File: rtl/seqnsdet.sv
// seqnsdet: overlapping 1-0-1-0 serial pattern detector (Moore FSM).
// Ports: din (serial bit), reset (async, active-high), clk, y (detect flag).
module seqnsdet (
  input  logic din,
  input  logic reset,
  input  logic clk,
  output logic y
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GOT1    = 3'd1,
    GOT10   = 3'd2,
    GOT101  = 3'd3,
    GOT1010 = 3'd4
  } state_t;

  // Declaration values give a defined power-up state in
  // simulation even when reset is never asserted.
  state_t state = IDLE;
  logic   y_q   = 1'b0;

  assign y = y_q;

  // y_q is loaded with the decode of the state being entered,
  // so it is always exactly (state == GOT1010) yet comes
  // straight from a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      y_q   <= 1'b0;
    end else begin
      y_q <= 1'b0;
      unique case (state)
        IDLE: begin
          state <= din ? GOT1 : IDLE;
        end
        GOT1: begin
          state <= din ? GOT1 : GOT10;
        end
        GOT10: begin
          state <= din ? GOT101 : IDLE;
        end
        GOT101: begin
          if (din) begin
            state <= GOT1;
          end else begin
            state <= GOT1010;
            y_q   <= 1'b1;
          end
        end
        // Trailing "10" overlaps into the next pattern.
        GOT1010: begin
          state <= din ? GOT101 : IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seqnsdet.sv
// tb_seqnsdet: self-checking bench for the 1-0-1-0 detector.
// Reference: y is high iff the last four bits since reset are 1,0,1,0.
module tb_seqnsdet;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic din   = 1'b0;
  logic y;

  int errs   = 0;
  int checks = 0;

  bit hist[$];

  seqnsdet dut (
    .din   (din),
    .reset (reset),
    .clk   (clk),
    .y     (y)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic exp_y();
    int n;
    n = hist.size();
    if (n < 4) return 1'b0;
    return (hist[n-4] == 1'b1) && (hist[n-3] == 1'b0) &&
           (hist[n-2] == 1'b1) && (hist[n-1] == 1'b0);
  endfunction

  // Drive one bit, let the next rising edge sample it,
  // and return 1 time unit after that edge.
  task automatic step(input bit b);
    din = b;
    @(posedge clk);
    hist.push_back(b);
    #1;
  endtask

  // Called 1 unit after a rising edge: assert reset,
  // hold for two edges, release between edges.
  task automatic reset_2cyc();
    reset = 1'b1;
    hist.delete();
    #1;
    checks++;
    if (y !== 1'b0) begin
      errs++;
      $display("FAIL reset_async: y=%b required 0", y);
    end
    repeat (2) begin
      din = $urandom_range(0, 1);
      @(posedge clk);
      #1;
      checks++;
      if (y !== 1'b0) begin
        errs++;
        $display("FAIL reset_held: y=%b required 0", y);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_poweron();
    #1;
    checks++;
    if (y !== 1'b0) begin
      errs++;
      $display("FAIL poweron: y=%b required 0", y);
    end
  endtask

  // No reset; rising edges at 5,15,...
  task automatic test_no_reset_vector();
    bit   seq[$];
    bit   ev[$];
    logic e;
    seq = '{0,1,0,1,0,1,0,1,1,1};
    ev  = '{0,0,0,0,1,0,1,0,0,0};
    foreach (seq[i]) begin
      step(seq[i]);
      e = ev[i];
      checks++;
      if (y !== e || y !== exp_y()) begin
        errs++;
        $display("FAIL no_reset_vec t=%0t bit%0d: y=%b required %b",
                 $time, i, y, e);
      end
      #4;
      checks++;
      if (y !== e) begin
        errs++;
        $display("FAIL no_reset_hold t=%0t: y=%b required %b",
                 $time, y, e);
      end
      #(-4 + 4);
    end
  endtask

  task automatic test_reset_then_detect();
    bit seq[$];
    bit ev[$];
    logic e;
    reset_2cyc();
    seq = '{1,1,0,1,0};
    ev  = '{0,0,0,0,1};
    foreach (seq[i]) begin
      step(seq[i]);
      e = ev[i];
      checks++;
      if (y !== e || y !== exp_y()) begin
        errs++;
        $display("FAIL reset_detect bit%0d: y=%b required %b", i, y, e);
      end
    end
  endtask

  task automatic test_no_match();
    bit seq[$];
    reset_2cyc();
    seq = '{1,0,0,1,0};
    foreach (seq[i]) begin
      step(seq[i]);
      checks++;
      if (y !== 1'b0) begin
        errs++;
        $display("FAIL no_match bit%0d: y=%b required 0", i, y);
      end
    end
  endtask

  task automatic test_reset_midpattern();
    bit seq[$];
    bit ev[$];
    reset_2cyc();
    seq = '{1,0,1};
    foreach (seq[i]) step(seq[i]);
    reset = 1'b1;
    hist.delete();
    #2;
    checks++;
    if (y !== 1'b0) begin
      errs++;
      $display("FAIL mid_reset_async: y=%b required 0", y);
    end
    reset = 1'b0;
    seq = '{0,1,0,1,0};
    ev  = '{0,0,0,0,1};
    foreach (seq[i]) begin
      step(seq[i]);
      checks++;
      if (y !== ev[i] || y !== exp_y()) begin
        errs++;
        $display("FAIL mid_reset bit%0d: y=%b required %b", i, y, ev[i]);
      end
    end
  endtask

  task automatic test_reset_while_high();
    bit seq[$];
    reset_2cyc();
    seq = '{1,0,1,0};
    foreach (seq[i]) step(seq[i]);
    checks++;
    if (y !== 1'b1) begin
      errs++;
      $display("FAIL high_before_reset: y=%b required 1", y);
    end
    reset = 1'b1;
    hist.delete();
    #1;
    checks++;
    if (y !== 1'b0) begin
      errs++;
      $display("FAIL high_reset_async: y=%b required 0", y);
    end
    reset = 1'b0;
  endtask

  task automatic test_ones_run();
    int hits;
    reset_2cyc();
    hits = 0;
    for (int i = 0; i < 11; i++) begin
      step((i < 8) ? 1'b1 : ((i == 9) ? 1'b1 : 1'b0));
      if (y === 1'b1) hits++;
      checks++;
      if (y !== exp_y()) begin
        errs++;
        $display("FAIL ones_run bit%0d: y=%b required %b", i, y, exp_y());
      end
    end
    checks++;
    if (hits != 1 || y !== 1'b1) begin
      errs++;
      $display("FAIL ones_run_count: hits=%0d y=%b required 1 and 1",
               hits, y);
    end
  endtask

  task automatic test_back_to_back();
    bit seq[$];
    bit ev[$];
    reset_2cyc();
    seq = '{1,0,1,0,1,0,0,0,0};
    ev  = '{0,0,0,1,0,1,0,0,0};
    foreach (seq[i]) begin
      step(seq[i]);
      checks++;
      if (y !== ev[i] || y !== exp_y()) begin
        errs++;
        $display("FAIL back_to_back bit%0d: y=%b required %b",
                 i, y, ev[i]);
      end
    end
  endtask

  task automatic test_random();
    bit   b;
    logic e;
    reset_2cyc();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        hist.delete();
        #1;
        checks++;
        if (y !== 1'b0) begin
          errs++;
          $display("FAIL rand_reset%0d: y=%b required 0", i, y);
        end
        reset = 1'b0;
      end
      b = ($urandom_range(0, 99) < 55);
      // Junk on din between edges must not matter.
      din = $urandom_range(0, 1);
      #1;
      din = ~din;
      #1;
      e = exp_y();
      checks++;
      if (y !== e) begin
        errs++;
        $display("FAIL rand_glitch%0d: y=%b required %b", i, y, e);
      end
      step(b);
      e = exp_y();
      checks++;
      if (y !== e) begin
        errs++;
        $display("FAIL rand%0d: y=%b required %b", i, y, e);
      end
    end
  endtask

  initial begin
    test_poweron();
    test_no_reset_vector();
    test_reset_then_detect();
    test_no_match();
    test_reset_midpattern();
    test_reset_while_high();
    test_ones_run();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/seqnsdet.md
SEQNSDET -- requirements
Module: seqnsdet

Interface
REQ-001 Parameters: none; the detected pattern is fixed at 1-0-1-0 (first bit first).
REQ-002 Port order is fixed for positional instantiation: din, reset, clk, y.
REQ-003 clk    input  1  single clock; all state updates occur on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset; forces IDLE immediately.
REQ-005 din    input  1  serial data bit, sampled on each rising clk edge.
REQ-006 y      output 1  detect flag; high for exactly the cycle(s) the FSM is in state GOT1010.

Function
REQ-007 The block SHALL be a Moore FSM with five states:
- IDLE: no prefix matched.
- GOT1: "1" matched.
- GOT10: "10" matched.
- GOT101: "101" matched.
- GOT1010: full pattern matched.
REQ-008 Detection SHALL be overlapping: a pattern's trailing "10" counts as a prefix of the next pattern.
REQ-009 Transitions on each rising clk edge (din=0 / din=1):
- IDLE -> IDLE / GOT1.
- GOT1 -> GOT10 / GOT1.
- GOT10 -> IDLE / GOT101.
- GOT101 -> GOT1010 / GOT1.
- GOT1010 -> IDLE / GOT101.
REQ-010 y SHALL be a function of current state only: y=1 iff state==GOT1010, else 0.
REQ-011 y SHALL NOT depend combinationally on din.
REQ-012 Latency: y SHALL rise in the same clock edge that samples the final "0" of the pattern, and hold for one full clock period.
REQ-013 y SHALL be glitch-free, either registered or decoded from a one-hot/registered state.
REQ-014 Back-to-back patterns "101010" SHALL assert y on the 4th and 6th sampled bits, with y low for one cycle between them.
REQ-015 A run of consecutive 1s SHALL keep the FSM in GOT1; consecutive 0s SHALL keep it in IDLE.
REQ-016 Any unused/illegal state encoding SHALL transition to IDLE on the next edge with y=0.
REQ-017 din changes between rising edges SHALL have no effect on state or y.

Reset
REQ-018 While reset=1, state SHALL be IDLE and y SHALL be 0, regardless of clk and din.
REQ-019 Reset assertion SHALL take effect without a clock edge.
REQ-020 Reset deassertion SHALL be followed by normal sampling from the next rising edge.
REQ-021 Reset asserted mid-pattern (e.g. in GOT101) SHALL discard the partial match; a full 1-0-1-0 is then required to detect.
REQ-022 The state register SHALL carry a simulation initial value of IDLE, so a bench that never asserts reset sees y=0, not X.

Verification
REQ-023 No reset, clk period 10 (rising edges at 5, 15, ...), din sampled sequence 0,1,0,1,0,1,0,1,1,1 -> y=0 before t=45, y=1 over 45-55, y=0 over 55-65, y=1 over 65-75, y=0 thereafter.
REQ-024 reset=1 for 2 cycles, then din 1,1,0,1,0 -> y=1 only after the 5th sampled bit, for one cycle.
REQ-025 din 1,0,0,1,0 -> y stays 0 (the "00" returns the FSM to IDLE).
REQ-026 din 1,0,1 then reset pulse asserted between edges, then din 0 -> y stays 0 and reset drives y=0 asynchronously.
REQ-027 din 1,0,1,0 followed by reset asserted while y=1 -> y drops to 0 immediately, before the next clk edge.
REQ-028 din held 1 for 8 cycles, then 0,1,0 -> y=1 exactly once, after the final 0.
